regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter feeding a single register-file write port.
// Optional build macro WB_ZERO_REG_DROP_EN: accepted writes to register 0 never raise wr_en.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        v0,
    input  logic [4:0]  a0,
    input  logic [31:0] d0,
    output logic        rdy0,
    input  logic        v1,
    input  logic [4:0]  a1,
    input  logic [31:0] d1,
    output logic        rdy1,
    input  logic        hold,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_sel,
    output logic [7:0]  conflict_cnt
);

    logic        last;
    logic        xfer;
    logic        sel;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        contention;
    logic        write_ok;

    // last names the most recent winner, so a tie goes to the other requester
    always_comb begin
        rdy0 = !rst && !hold && v0 && (!v1 || last);
        rdy1 = !rst && !hold && v1 && (!v0 || !last);
    end

    assign xfer       = rdy0 || rdy1;
    assign sel        = rdy1;
    assign sel_addr   = sel ? a1 : a0;
    assign sel_data   = sel ? d1 : d0;
    assign contention = (v0 && v1) || (hold && (v0 || v1));

`ifdef WB_ZERO_REG_DROP_EN
    assign write_ok = (sel_addr != 5'd0);
`else
    assign write_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_sel  <= 1'b0;
        end else if (xfer) begin
            last    <= sel;
            wr_en   <= write_ok;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_sel  <= sel;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt <= '0;
        else if (contention && (conflict_cnt != 8'hFF))
            conflict_cnt <= conflict_cnt + 8'd1;
    end

endmodule
